// File: rtl/kb_ascii_stream.sv
// rtl/kb_ascii_stream.sv - PS/2 scan-code to ASCII (or hex dump) bridge with FWFT output FIFO
module kb_ascii_stream #(
    parameter int FIFO_W    = 4,
    parameter int MODE      = 0,
    parameter int REPEAT_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_valid,
    input  logic [7:0]        scan_byte,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              caps_led,
    output logic              overflow,
    output logic [FIFO_W:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_W;
    localparam logic [FIFO_W:0]   CNT_ONE     = {{FIFO_W{1'b0}}, 1'b1};
    localparam logic [FIFO_W:0]   CNT_FULL    = {1'b1, {FIFO_W{1'b0}}};
    localparam logic [FIFO_W:0]   CNT_HEX_MAX = CNT_FULL - {{(FIFO_W-1){1'b0}}, 2'd3};
    localparam logic [FIFO_W-1:0] PTR_ONE     = {{(FIFO_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    state_t            state, state_nx;
    logic              is_make, is_break;
    logic              shift_l, shift_r, caps, caps_held;
    logic [7:0]        last_make;
    logic              repeat_drop;
    logic [8:0]        xl;
    logic              asc_valid;
    logic [7:0]        asc_data;
    logic [7:0]        hex_byte;
    logic [1:0]        hex_cnt;
    logic              hex_busy, hex_start, hex_drop;
    logic              push_en;
    logic [7:0]        push_data;
    logic              fifo_full, do_push, do_pop;
    logic [7:0]        mem [0:DEPTH-1];
    logic [FIFO_W-1:0] wr_ptr, rd_ptr;
    logic [FIFO_W:0]   count;

    // Returns {mapped, character}; unmapped codes yield mapped=0.
    function automatic logic [8:0] xlate(input logic [7:0] code, input logic shift, input logic cl);
        logic [7:0] lc, dn, ds;
        logic [8:0] r;
        lc = 8'h00;
        dn = 8'h00;
        ds = 8'h00;
        r  = 9'h000;
        case (code)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
            8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
            8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
            8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
            8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            8'h45: begin dn = "0"; ds = ")"; end
            8'h16: begin dn = "1"; ds = "!"; end
            8'h1E: begin dn = "2"; ds = "@"; end
            8'h26: begin dn = "3"; ds = "#"; end
            8'h25: begin dn = "4"; ds = "$"; end
            8'h2E: begin dn = "5"; ds = "%"; end
            8'h36: begin dn = "6"; ds = "^"; end
            8'h3D: begin dn = "7"; ds = "&"; end
            8'h3E: begin dn = "8"; ds = "*"; end
            8'h46: begin dn = "9"; ds = "("; end
            8'h29: r = 9'h120;
            8'h5A: r = 9'h10D;
            8'h66: r = 9'h108;
            default: r = 9'h000;
        endcase
        if (lc != 8'h00)
            r = {1'b1, (shift ^ cl) ? (lc - 8'h20) : lc};
        else if (dn != 8'h00)
            r = {1'b1, shift ? ds : dn};
        return r;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        is_make  = 1'b0;
        is_break = 1'b0;
        if (scan_valid && (MODE == 0)) begin
            case (state)
                S_IDLE: begin
                    if (scan_byte == 8'hF0)      state_nx = S_BRK;
                    else if (scan_byte == 8'hE0) state_nx = S_EXT;
                    else                         is_make  = 1'b1;
                end
                S_BRK: begin
                    is_break = 1'b1;
                    state_nx = S_IDLE;
                end
                S_EXT:     state_nx = (scan_byte == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: state_nx = S_IDLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    assign repeat_drop = (REPEAT_EN == 0) && (scan_byte == last_make);
    assign xl          = xlate(scan_byte, shift_l | shift_r, caps);

    // Translation is registered so the FIFO write happens one cycle after the byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
            last_make <= 8'h00;
            asc_valid <= 1'b0;
            asc_data  <= 8'h00;
        end else begin
            asc_valid <= 1'b0;
            if (is_make) begin
                if (scan_byte == 8'h12) begin
                    shift_l <= 1'b1;
                end else if (scan_byte == 8'h59) begin
                    shift_r <= 1'b1;
                end else if (scan_byte == 8'h58) begin
                    if (!caps_held) caps <= ~caps;
                    caps_held <= 1'b1;
                end else if (!repeat_drop) begin
                    last_make <= scan_byte;
                    asc_valid <= xl[8];
                    asc_data  <= xl[7:0];
                end
            end
            if (is_break) begin
                if (scan_byte == 8'h12) shift_l   <= 1'b0;
                if (scan_byte == 8'h59) shift_r   <= 1'b0;
                if (scan_byte == 8'h58) caps_held <= 1'b0;
                if (scan_byte == last_make) last_make <= 8'h00;
            end
        end
    end

    // A hex group needs three free slots up front so it is never split.
    assign hex_busy  = (hex_cnt != 2'd0);
    assign hex_start = (MODE == 1) && scan_valid && !hex_busy && (count <= CNT_HEX_MAX);
    assign hex_drop  = (MODE == 1) && scan_valid && !hex_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            hex_cnt  <= 2'd0;
            hex_byte <= 8'h00;
        end else if (hex_start) begin
            hex_cnt  <= 2'd3;
            hex_byte <= scan_byte;
        end else if (hex_busy) begin
            hex_cnt  <= hex_cnt - 2'd1;
        end
    end

    always_comb begin
        push_en   = 1'b0;
        push_data = 8'h00;
        if (MODE == 1) begin
            push_en = hex_busy;
            case (hex_cnt)
                2'd3:    push_data = hex_char(hex_byte[7:4]);
                2'd2:    push_data = hex_char(hex_byte[3:0]);
                default: push_data = 8'h20;
            endcase
        end else begin
            push_en   = asc_valid;
            push_data = asc_data;
        end
    end

    assign fifo_full = (count == CNT_FULL);
    assign do_pop    = (count != '0) && out_ready;
    assign do_push   = push_en && !fifo_full;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (!do_push && do_pop) count <= count - CNT_ONE;
            if ((push_en && fifo_full) || hex_drop) overflow <= 1'b1;
        end
    end

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;
    assign caps_led   = caps;

endmodule

// File: tb/tb_kb_ascii_stream.sv
// tb/tb_kb_ascii_stream.sv - directed table-driven bench for kb_ascii_stream
module tb_kb_ascii_stream;

    logic       clk = 1'b0;
    logic       rst, scan_valid, out_ready;
    logic [7:0] scan_byte;
    logic [7:0] od [3];
    logic       ov [3];
    logic       cl [3];
    logic       of [3];
    logic [4:0] fc [3];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kb_ascii_stream #(.FIFO_W(4), .MODE(0), .REPEAT_EN(0)) d0 (
        .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_byte(scan_byte),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .caps_led(cl[0]), .overflow(of[0]), .fifo_count(fc[0]));

    kb_ascii_stream #(.FIFO_W(4), .MODE(0), .REPEAT_EN(1)) d1 (
        .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_byte(scan_byte),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .caps_led(cl[1]), .overflow(of[1]), .fifo_count(fc[1]));

    kb_ascii_stream #(.FIFO_W(4), .MODE(1), .REPEAT_EN(0)) d2 (
        .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_byte(scan_byte),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
        .caps_led(cl[2]), .overflow(of[2]), .fifo_count(fc[2]));

    typedef struct {
        logic [7:0] code;
        logic       shift;
        logic       has_out;
        logic [7:0] exp;
    } vec_t;

    vec_t       vt [15];
    logic [7:0] keys [17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_valid = 1'b1;
        scan_byte  = b;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pop_expect(input int s, input logic [7:0] exp, input string name);
        int n = 0;
        while (!ov[s] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ov[s]) begin
            chk({name, " timeout"}, 0, 1);
        end else begin
            chk(name, int'(od[s]), int'(exp));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        vt[0]  = '{8'h1C, 1'b0, 1'b1, 8'h61};
        vt[1]  = '{8'h1C, 1'b1, 1'b1, 8'h41};
        vt[2]  = '{8'h1A, 1'b0, 1'b1, 8'h7A};
        vt[3]  = '{8'h4D, 1'b1, 1'b1, 8'h50};
        vt[4]  = '{8'h45, 1'b0, 1'b1, 8'h30};
        vt[5]  = '{8'h45, 1'b1, 1'b1, 8'h29};
        vt[6]  = '{8'h16, 1'b1, 1'b1, 8'h21};
        vt[7]  = '{8'h1E, 1'b1, 1'b1, 8'h40};
        vt[8]  = '{8'h3E, 1'b1, 1'b1, 8'h2A};
        vt[9]  = '{8'h36, 1'b1, 1'b1, 8'h5E};
        vt[10] = '{8'h29, 1'b0, 1'b1, 8'h20};
        vt[11] = '{8'h5A, 1'b0, 1'b1, 8'h0D};
        vt[12] = '{8'h66, 1'b1, 1'b1, 8'h08};
        vt[13] = '{8'h0E, 1'b0, 1'b0, 8'h00};
        vt[14] = '{8'h75, 1'b0, 1'b0, 8'h00};
        keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};

        rst = 1'b1; scan_valid = 1'b0; scan_byte = 8'h00; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst out_valid", int'(ov[0]), 0);
        chk("rst out_data", int'(od[0]), 0);
        chk("rst caps_led", int'(cl[0]), 0);
        chk("rst overflow", int'(of[0]), 0);
        chk("rst fifo_count", int'(fc[0]), 0);
        chk("rst hex out_valid", int'(ov[2]), 0);

        for (int i = 0; i < 15; i++) begin
            do_reset();
            if (vt[i].shift) send(8'h12);
            send(vt[i].code);
            if (vt[i].has_out) begin
                pop_expect(0, vt[i].exp, $sformatf("vec%0d", i));
            end else begin
                repeat (4) @(negedge clk);
                chk($sformatf("vec%0d unmapped", i), int'(ov[0]), 0);
                chk($sformatf("vec%0d overflow", i), int'(of[0]), 0);
            end
        end

        do_reset();
        send(8'h1C); send(8'hF0); send(8'h1C);
        repeat (4) @(negedge clk);
        chk("make/break count", int'(fc[0]), 1);
        pop_expect(0, 8'h61, "make/break char");
        send(8'h1C);
        pop_expect(0, 8'h61, "idle after break");

        do_reset();
        send(8'h12); send(8'h1C);
        pop_expect(0, 8'h41, "shift a");
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        send(8'h58);
        chk("caps_led after 58", int'(cl[0]), 1);
        send(8'hF0); send(8'h58);
        send(8'h1C);
        pop_expect(0, 8'h41, "caps a");
        send(8'h16);
        pop_expect(0, 8'h31, "caps digit");
        send(8'h12); send(8'h1C);
        pop_expect(0, 8'h61, "caps+shift a");
        send(8'h58);
        chk("caps toggle off", int'(cl[0]), 0);
        send(8'h58);
        chk("caps held no toggle", int'(cl[0]), 0);

        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        repeat (4) @(negedge clk);
        chk("repeat drop count", int'(fc[0]), 2);
        chk("repeat pass count", int'(fc[1]), 4);
        for (int i = 0; i < 4; i++) pop_expect(1, 8'h61, $sformatf("repeat pass %0d", i));

        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h16);
        repeat (4) @(negedge clk);
        chk("ext count", int'(fc[0]), 1);
        pop_expect(0, 8'h31, "ext then 1");

        do_reset();
        for (int i = 0; i < 16; i++) send(keys[i]);
        repeat (3) @(negedge clk);
        chk("full no overflow", int'(of[0]), 0);
        send(keys[16]);
        repeat (3) @(negedge clk);
        chk("full count", int'(fc[0]), 16);
        chk("full overflow", int'(of[0]), 1);
        for (int i = 0; i < 16; i++) pop_expect(0, 8'h61 + 8'(i), $sformatf("full char %0d", i));
        chk("sticky overflow", int'(of[0]), 1);

        do_reset();
        out_ready = 1'b1;
        send(8'hF0);
        @(negedge clk);
        chk("hex c0 valid", int'(ov[2]), 1);
        chk("hex c0", int'(od[2]), 8'h46);
        @(negedge clk);
        chk("hex c1", int'(od[2]), 8'h30);
        @(negedge clk);
        chk("hex c2", int'(od[2]), 8'h20);
        @(negedge clk);
        chk("hex drained", int'(ov[2]), 0);
        out_ready = 1'b0;

        do_reset();
        send(8'h3A); send(8'h5B);
        repeat (4) @(negedge clk);
        chk("hex busy count", int'(fc[2]), 3);
        chk("hex busy overflow", int'(of[2]), 1);
        pop_expect(2, 8'h33, "hex 3A hi");
        pop_expect(2, 8'h41, "hex 3A lo");
        pop_expect(2, 8'h20, "hex 3A sp");

        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(8'(i));
            repeat (4) @(negedge clk);
        end
        chk("hex fill count", int'(fc[2]), 15);
        chk("hex fill no ovf", int'(of[2]), 0);
        send(8'hAB);
        repeat (4) @(negedge clk);
        chk("hex no room count", int'(fc[2]), 15);
        chk("hex no room ovf", int'(of[2]), 1);

        do_reset();
        for (int i = 0; i < 5; i++) send(keys[i]);
        send(8'hF0);
        repeat (2) @(negedge clk);
        chk("pre-rst count", int'(fc[0]), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst count", int'(fc[0]), 0);
        chk("mid rst valid", int'(ov[0]), 0);
        send(8'h1C);
        pop_expect(0, 8'h61, "prefix discarded");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kb_ascii_stream.md
# kb_ascii_stream

Parametrised keyboard-to-character bridge between the PS/2 byte receiver and the UART transmitter. It consumes raw scan-code bytes, tracks break/extended prefixes, shift and caps-lock state, and suppresses typematic repeats. It translates make codes to ASCII, or to a hex dump of raw bytes in debug mode, and buffers the characters in an internal FIFO drained through a valid/ready handshake.

## Interface
- FIFO_W, 4, FIFO address width; depth = 2**FIFO_W characters
- MODE, 0, 0 = ASCII translation; 1 = hex dump (every raw byte becomes 3 characters)
- REPEAT_EN, 0, 1 = pass typematic repeats; 0 = drop a repeated make of a key still held
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- scan_valid  in  1  one-cycle strobe: scan_byte holds a new received byte
- scan_byte  in  8  raw PS/2 scan-code byte
- out_data  out  8  FIFO head character; 0x00 when empty
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data this cycle
- caps_led  out  1  current caps-lock state
- overflow  out  1  sticky: a character or group was dropped; cleared only by rst
- fifo_count  out  FIFO_W+1  characters currently held

## Operation
- Prefix FSM, MODE=0: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
  - IDLE: F0 goes to BRK; E0 goes to EXT; any other byte is a make code, stays IDLE.
  - BRK: byte is a break code, returns to IDLE.
  - EXT: F0 goes to EXT_BRK; other bytes are dropped, return to IDLE.
  - EXT_BRK: byte dropped, returns to IDLE.
- Make handling:
  - 0x12 sets shift_l; 0x59 sets shift_r.
  - 0x58 toggles caps only if caps_held=0, then sets caps_held.
  - Other codes: if REPEAT_EN=0 and the code equals last_make, drop it. Otherwise set last_make to the code, translate, and push.
- Break handling: 0x12/0x59 clear their shift flag; 0x58 clears caps_held; a code equal to last_make clears last_make to 0x00. Breaks never push.
- Translation:
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z. Uppercase when (shift_l|shift_r) XOR caps.
  - Digits: 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9. With shift: ) ! @ # $ % ^ & * (. Caps has no effect.
  - 29 gives 0x20; 5A gives 0x0D; 66 gives 0x08.
  - Unmapped codes: dropped silently; overflow unaffected.
- MODE=1: no FSM or translation. Each byte pushes the upper nibble, the lower nibble (0-9, A-F as ASCII uppercase), then 0x20.
  - If free slots < 3 at latch time, the whole group is dropped and overflow is set.
  - A scan_valid while a group is still being written is dropped and sets overflow.
- FIFO: first-word-fall-through.
  - Pop when out_valid & out_ready.
  - Push when full: drop and set overflow, even if a pop occurs in the same cycle (full is judged on count before pop).
  - Simultaneous push and pop when not full: count unchanged, both occur.
  - Pointers wrap modulo 2**FIFO_W.

## Timing
- Reset values: FSM in IDLE; shift_l, shift_r, caps, caps_held = 0; last_make = 0x00; FIFO empty; out_valid=0, out_data=0x00, caps_led=0, overflow=0, fifo_count=0.
- Reset mid-operation discards pending prefixes, partially written hex groups and all FIFO contents.
- ASCII latency: scan_valid in cycle N, FIFO empty, so out_valid=1 in cycle N+2.
- Hex latency: characters written on the edges ending cycles N+1, N+2 and N+3; the group is busy through N+3.
- caps_led updates in cycle N+1 after the 0x58 make.
- Popping in cycle M advances out_data in cycle M+1.
- out_ready is ignored when out_valid=0.

## Test plan
- MODE=0: bytes 1C, F0 1C → exactly one out_data 0x61; FSM back in IDLE.
- MODE=0: bytes 12, 1C, F0 1C, F0 12, 58, F0 58, 1C → 0x41 then 0x41; caps_led=1 after 58.
- MODE=0, REPEAT_EN=0: bytes 1C, 1C, 1C, F0 1C, 1C → two 0x61. With REPEAT_EN=1 → four 0x61.
- MODE=0: bytes E0 75, E0 F0 75, 16 → only 0x31 output. Hold out_ready=0 while 17 keys are pressed with FIFO_W=4 → fifo_count=16, overflow=1, first 16 characters intact.
- MODE=1: byte 0xF0 → 0x46, 0x30, 0x20. With out_ready=1 every cycle, characters drain one per cycle.
- Assert rst with FIFO holding 5 characters after an F0 prefix → next cycle fifo_count=0 and out_valid=0. Then byte 1C → 0x61, because the prefix was discarded.
